// File: rtl/adder_arb_pkg.sv
// Shared definitions for adder_arbiter: FSM state encoding, default datapath
// width and the circular search used to pick the next requester.
package adder_arb_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, RESP} arb_state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int MAX_REQ       = 8;

    // Nearest set request after ptr in circular order; ptr itself has lowest priority.
    function automatic int rr_next(input logic [MAX_REQ-1:0] req, input int ptr, input int nreq);
        int idx;
        rr_next = ptr;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= nreq) begin
                idx = ptr + k;
                if (idx >= nreq) idx = idx - nreq;
                if (req[idx[$clog2(MAX_REQ)-1:0]]) rr_next = idx;
            end
        end
    endfunction

endpackage

// File: rtl/adder_arbiter_rr.sv
// Round-robin grant selection over NREQ requesters, holding the pointer to the
// most recent winner so the search always starts just after it.
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic                    advance,
    output logic                    grant_valid,
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int ID_W = $clog2(NREQ);

    logic [ID_W-1:0] ptr;

    assign grant_valid = |req;
    assign grant_id    = ID_W'(rr_next(MAX_REQ'(req), int'(ptr), NREQ));

    // Starting at NREQ-1 makes requester 0 the first winner after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= ID_W'(NREQ - 1);
        end else if (advance) begin
            ptr <= grant_id;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one sequential adder between NREQ requesters, one transaction at a time.
// Optional watchdog on the adder's ready: define ADDER_ARB_TIMEOUT_EN.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    add_start,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    input  logic                    add_ready,
    input  logic [WIDTH-1:0]        add_res,
    input  logic                    add_overflow,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]        rsp_res,
    output logic                    rsp_overflow,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int ID_W = $clog2(NREQ);

    arb_state_t      state;
    logic [ID_W-1:0] op_id;
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;
    logic            advance;

    assign advance = (state == IDLE) && grant_valid;
    assign busy    = (state != IDLE);

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk        (clk),
        .rst        (rst),
        .req        (req_valid),
        .advance    (advance),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

`ifdef ADDER_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] timer;
    logic             timed_out;

    assign timed_out = (state == WAIT) && !add_ready && (timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || (state != WAIT) || add_ready || timed_out) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end
`else
    // Without the watchdog no response can be an error (TIMEOUT is always positive).
    assign rsp_err = (TIMEOUT < 0);
`endif

    // ARM exists only to skip the cycle where the adder may still show a stale ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op_id        <= '0;
            req_ready    <= '0;
            add_start    <= 1'b0;
            add_a        <= '0;
            add_b        <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_res      <= '0;
            rsp_overflow <= 1'b0;
`ifdef ADDER_ARB_TIMEOUT_EN
            rsp_err      <= 1'b0;
`endif
        end else begin
            req_ready <= '0;
            add_start <= 1'b0;
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        req_ready <= NREQ'(1) << grant_id;
                        add_a     <= req_a[WIDTH*grant_id +: WIDTH];
                        add_b     <= req_b[WIDTH*grant_id +: WIDTH];
                        op_id     <= grant_id;
                        add_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: state <= ARM;
                ARM:   state <= WAIT;
                WAIT: begin
                    if (add_ready) begin
                        rsp_valid    <= 1'b1;
                        rsp_id       <= op_id;
                        rsp_res      <= add_res;
                        rsp_overflow <= add_overflow;
                        state        <= RESP;
`ifdef ADDER_ARB_TIMEOUT_EN
                    end else if (timed_out) begin
                        rsp_valid    <= 1'b1;
                        rsp_id       <= op_id;
                        rsp_res      <= '0;
                        rsp_overflow <= 1'b0;
                        rsp_err      <= 1'b1;
                        state        <= RESP;
`endif
                    end
                end
                RESP: begin
                    add_a        <= '0;
                    add_b        <= '0;
                    rsp_id       <= '0;
                    rsp_res      <= '0;
                    rsp_overflow <= 1'b0;
`ifdef ADDER_ARB_TIMEOUT_EN
                    rsp_err      <= 1'b0;
`endif
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
